vga_fetch_ctrl: RTL
===================

Name: vga_fetch_ctrl

Overview:
- Schedules burst reads of the display frame from the SDRAM frame store into the VGA line FIFO that feeds the 800x600 VGA timing generator.
- Tracks the display bank (double-buffered against the OV7670 write path), issues one burst at a time over a REQ/ACK/DONE handshake, gates each burst on FIFO free space, and restarts cleanly at every vertical blank.
- Also flags FIFO underrun seen by the VGA reader.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- BURST_LEN, 256, maximum words per SDRAM read burst
- FIFO_DEPTH, 1024, line FIFO capacity in words
- ADDR_W, 22, SDRAM word address width
- BANK_SIZE, 524288, word offset of bank 1 from bank 0 (bank 0 base = 0)
- CLR_CYCLES, 4, FIFO_CLR pulse width (covers dual-clock FIFO reset)

Ports:
- CLK_40M  in  1  pixel/system clock
- RST  in  1  reset
- VSYNC_START  in  1  one-cycle pulse at start of vertical blank
- WR_FRAME_DONE  in  1  one-cycle pulse: camera writer completed a frame in WR_BANK
- WR_BANK  in  1  bank just completed by the writer
- FIFO_WORDS  in  11  line FIFO fill level, write side
- FIFO_RD  in  1  VGA reader pops the FIFO this cycle
- FIFO_EMPTY  in  1  line FIFO empty
- RD_REQ  out  1  burst read request
- RD_ADDR  out  ADDR_W  burst start word address
- RD_LEN  out  9  burst length in words (1..BURST_LEN)
- RD_ACK  in  1  SDRAM controller accepted the request
- RD_DONE  in  1  one-cycle pulse: last word of the burst written to the FIFO
- FIFO_CLR  out  1  line FIFO clear
- RD_BANK  out  1  bank currently being displayed
- UNDERRUN  out  1  sticky underrun flag, cleared per frame

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: RD_REQ=0, RD_ADDR=0, RD_LEN=0, FIFO_CLR=0, RD_BANK=0, UNDERRUN=0. State=IDLE, swap_pending=0, words_left=0.
- FRAME_WORDS = H_ACTIVE*V_ACTIVE (480000 at defaults, 19 bits).
- IDLE: wait for VSYNC_START, then go to CLEAR.
- CLEAR (frame start):
  - If swap_pending, RD_BANK <= latest_bank and swap_pending cleared.
  - RD_ADDR <= RD_BANK*BANK_SIZE; words_left <= FRAME_WORDS; UNDERRUN <= 0.
  - FIFO_CLR held high for exactly CLR_CYCLES cycles, then go to WAIT_SPACE.
- WAIT_SPACE:
  - len = min(BURST_LEN, words_left).
  - If words_left==0, go to DONE.
  - Else if FIFO_DEPTH - FIFO_WORDS >= len, latch RD_LEN=len and go to REQ; RD_REQ rises the next cycle.
- REQ:
  - RD_REQ, RD_ADDR and RD_LEN are held stable until the cycle RD_ACK=1. RD_REQ drops the cycle after ACK.
  - The request is never withdrawn before ACK, even on VSYNC_START. Go to BUSY.
- BUSY:
  - On RD_DONE: RD_ADDR += RD_LEN, words_left -= RD_LEN.
  - Then one SETTLE cycle, allowing FIFO_WORDS to reflect the burst, then WAIT_SPACE.
- DONE: frame fully fetched; wait for VSYNC_START, then go to CLEAR.
- VSYNC_START in WAIT_SPACE or DONE: go to CLEAR next cycle.
- VSYNC_START in REQ, BUSY or SETTLE: set restart_pending; finish the handshake (ACK, then DONE); go to CLEAR instead of WAIT_SPACE. Address/count updates from that burst are discarded.
- Bank swap:
  - WR_FRAME_DONE sets swap_pending=1 and latest_bank=WR_BANK; a later WR_FRAME_DONE overwrites latest_bank.
  - If WR_FRAME_DONE and VSYNC_START coincide, the new completion is used for that frame's CLEAR.
  - RD_BANK changes only in CLEAR.
- UNDERRUN set when FIFO_RD && FIFO_EMPTY. Cleared only in CLEAR or by reset. Set wins if it coincides with the clear.
- At most one burst outstanding. RD_ADDR never crosses the bank end: the last burst is truncated by words_left.
- Reset mid-burst: returns to IDLE immediately; the SDRAM controller is reset by the same RST.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, FRAME_WORDS
  - the state enum (IDLE, CLEAR, WAIT_SPACE, REQ, BUSY, SETTLE, DONE)
  - BANK_SIZE and the bank base address function
- One sub-module is natural: vga_bank_sel (swap_pending/latest_bank/RD_BANK logic, commit strobe from CLEAR).
- Burst sequencing FSM stays in vga_fetch_ctrl.

Test Plan:
- Reset, then VSYNC_START, FIFO_WORDS=0, ACK after 2 cycles, DONE after 260 cycles -> FIFO_CLR high exactly 4 cycles; first request ADDR=0, LEN=256; second ADDR=256; 1875 bursts total; then DONE and RD_REQ stays 0.
- Override H_ACTIVE=10, V_ACTIVE=3, BURST_LEN=8, FIFO_DEPTH=16 -> LEN sequence 8,8,8,6; addresses 0,8,16,24. With FIFO_WORDS held at 9, no request until FIFO_WORDS<=8.
- WR_FRAME_DONE with WR_BANK=1 mid-frame, then VSYNC_START -> RD_BANK=1 in CLEAR; first ADDR=524288. A second VSYNC_START without a new WR_FRAME_DONE -> RD_BANK stays 1.
- VSYNC_START while RD_REQ high and ACK withheld 5 cycles -> RD_REQ stays high until ACK; after DONE goes to CLEAR (no SETTLE/WAIT_SPACE); next ADDR=bank base.
- WR_FRAME_DONE (WR_BANK=1) coincident with VSYNC_START -> that frame displays bank 1.
- FIFO_RD with FIFO_EMPTY=1 -> UNDERRUN=1 next cycle, held until the following CLEAR. Simultaneous underrun and clear -> UNDERRUN=1.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared display geometry, fetch FSM states and frame bank addressing
package vga_pkg;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int BURST_LEN = 256;
  localparam int FIFO_DEPTH = 1024;
  localparam int ADDR_W = 22;
  localparam int BANK_SIZE = 524288;
  localparam int CLR_CYCLES = 4;
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_SPACE, REQ, BUSY, SETTLE, DONE} fetch_state_t;
  function automatic logic [31:0] bank_base(input logic bank, input int size);
    return bank ? 32'(size) : 32'd0;
  endfunction
endpackage

// File: rtl/vga_bank_sel.sv
// vga_bank_sel: display bank tracking against the camera writer, swapping only on commit
module vga_bank_sel (
  input  logic clk,
  input  logic rst,
  input  logic wr_frame_done,
  input  logic wr_bank,
  input  logic commit,
  output logic rd_bank,
  output logic next_bank
);
  logic swap_pending;
  logic latest_bank;
  assign next_bank = wr_frame_done ? wr_bank : swap_pending ? latest_bank : rd_bank;
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_pending <= 1'b0;
      latest_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      swap_pending <= !commit && (swap_pending || wr_frame_done);
      latest_bank <= wr_frame_done ? wr_bank : latest_bank;
      rd_bank <= commit ? next_bank : rd_bank;
    end
  end
endmodule

// File: rtl/vga_fetch_ctrl.sv
// vga_fetch_ctrl: schedules one-at-a-time SDRAM frame bursts into the VGA line FIFO
module vga_fetch_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int BURST_LEN = vga_pkg::BURST_LEN,
  parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH,
  parameter int ADDR_W = vga_pkg::ADDR_W,
  parameter int BANK_SIZE = vga_pkg::BANK_SIZE,
  parameter int CLR_CYCLES = vga_pkg::CLR_CYCLES
) (
  input  logic              CLK_40M,
  input  logic              RST,
  input  logic              VSYNC_START,
  input  logic              WR_FRAME_DONE,
  input  logic              WR_BANK,
  input  logic [10:0]       FIFO_WORDS,
  input  logic              FIFO_RD,
  input  logic              FIFO_EMPTY,
  output logic              RD_REQ,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [8:0]        RD_LEN,
  input  logic              RD_ACK,
  input  logic              RD_DONE,
  output logic              FIFO_CLR,
  output logic              RD_BANK,
  output logic              UNDERRUN
);
  localparam int FW = H_ACTIVE * V_ACTIVE;
  localparam int WL_W = $clog2(FW + 1);
  localparam int CW = $clog2(CLR_CYCLES + 1);
  fetch_state_t state, next_state;
  logic [WL_W-1:0] words_left;
  logic [CW-1:0] clr_cnt;
  logic [8:0] len;
  logic [ADDR_W-1:0] base_addr;
  logic restart_pending, restart_any, commit, next_bank, space_ok, in_burst;
  assign commit = state == CLEAR && clr_cnt == '0;
  assign restart_any = restart_pending || VSYNC_START;
  assign in_burst = state == REQ || state == BUSY || state == SETTLE;
  assign len = 32'(words_left) < 32'(BURST_LEN) ? 9'(words_left) : 9'(BURST_LEN);
  assign space_ok = FIFO_DEPTH - int'(FIFO_WORDS) >= int'(len);
  assign base_addr = ADDR_W'(bank_base(next_bank, BANK_SIZE));
  vga_bank_sel u_bank_sel (
    .clk(CLK_40M),
    .rst(RST),
    .wr_frame_done(WR_FRAME_DONE),
    .wr_bank(WR_BANK),
    .commit(commit),
    .rd_bank(RD_BANK),
    .next_bank(next_bank)
  );
  always_ff @(posedge CLK_40M) state <= RST ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       next_state = VSYNC_START ? CLEAR : IDLE;
      CLEAR:      next_state = clr_cnt == CW'(CLR_CYCLES - 1) ? WAIT_SPACE : CLEAR;
      WAIT_SPACE: next_state = VSYNC_START ? CLEAR : words_left == '0 ? DONE : space_ok ? REQ : WAIT_SPACE;
      REQ:        next_state = RD_ACK ? BUSY : REQ;
      BUSY:       next_state = !RD_DONE ? BUSY : restart_any ? CLEAR : SETTLE;
      SETTLE:     next_state = restart_any ? CLEAR : WAIT_SPACE;
      DONE:       next_state = VSYNC_START ? CLEAR : DONE;
      default:    next_state = IDLE;
    endcase
  end
  always_ff @(posedge CLK_40M) begin
    if (RST) begin
      clr_cnt <= '0;
      words_left <= '0;
      restart_pending <= 1'b0;
      RD_REQ <= 1'b0;
      RD_ADDR <= '0;
      RD_LEN <= '0;
      FIFO_CLR <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      clr_cnt <= state == CLEAR ? clr_cnt + 1'b1 : '0;
      restart_pending <= state == CLEAR ? 1'b0 : restart_pending || (VSYNC_START && in_burst);
      RD_REQ <= next_state == REQ;
      FIFO_CLR <= next_state == CLEAR;
      UNDERRUN <= (FIFO_RD && FIFO_EMPTY) || (UNDERRUN && !commit);
      RD_LEN <= state == WAIT_SPACE && next_state == REQ ? len : RD_LEN;
      if (commit) begin
        RD_ADDR <= base_addr;
        words_left <= WL_W'(FW);
      end else if (state == BUSY && RD_DONE && !restart_any) begin
        RD_ADDR <= RD_ADDR + ADDR_W'(RD_LEN);
        words_left <= words_left - WL_W'(RD_LEN);
      end
    end
  end
endmodule
